serial_ripple_subtractor: RTL and testbench

//   Bit-serial n-bit unsigned subtractor. Computes D = A - B one bit per clock,
//   LSB first, propagating a borrow bit through a single full-subtractor cell.

---
 rtl/serial_ripple_subtractor_if.sv | 14 +
 rtl/serial_ripple_subtractor.sv | 85 ++++++++
 tb/tb_serial_ripple_subtractor.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/serial_ripple_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master side issues start with A/B. The slave side returns D/Bout with busy/done.
interface serial_ripple_subtractor_if #(parameter int n = 4);
  logic         start;
  logic [n-1:0] A;
  logic [n-1:0] B;
  logic [n-1:0] D;
  logic         Bout;
  logic         busy;
  logic         done;

  modport master (output start, A, B, input D, Bout, busy, done);
  modport slave  (input start, A, B, output D, Bout, busy, done);
endinterface

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial unsigned subtractor D = A - B. It processes one bit per clock, LSB first,
// through a single full-subtractor cell. Operands are captured on start, and done pulses once per result.
module serial_ripple_subtractor #(
  parameter int n = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  serial_ripple_subtractor_if.slave   bus
);
  localparam int CW = (n > 1) ? $clog2(n) : 1;
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t         state, state_nxt;
  logic           accept;
  logic [n-1:0]   a_sr, b_sr, d_r;
  logic           bout_r, borrow;
  logic [CW-1:0]  cnt;
  logic           a, b, diff, borrow_nxt;
  logic [n-1:0]   d_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN:  if (cnt == LAST) state_nxt = FIN;
      FIN: begin
        // start seen in FIN is taken immediately for back-to-back throughput
        accept    = bus.start;
        state_nxt = bus.start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign a          = a_sr[0];
  assign b          = b_sr[0];
  assign diff       = a ^ b ^ borrow;
  assign borrow_nxt = (~a & b) | (~(a ^ b) & borrow);

  if (n == 1) begin : g_one
    assign d_shift = diff;
  end else begin : g_many
    assign d_shift = {diff, d_r[n-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      d_r    <= '0;
      bout_r <= 1'b0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr   <= bus.A;
      b_sr   <= bus.B;
      d_r    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      d_r    <= d_shift;
      borrow <= borrow_nxt;
      cnt    <= cnt + 1'b1;
      if (cnt == LAST) bout_r <= borrow_nxt;
    end
  end

  assign bus.D    = d_r;
  assign bus.Bout = bout_r;
  assign bus.busy = (state == RUN);
  assign bus.done = (state == FIN);
endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Randomized and directed checks of the serial subtractor at n=4 and n=8.
// Expected results come from (A-B) mod 2^n and (A<B).
module tb_serial_ripple_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_ripple_subtractor_if #(.n(4)) if4 ();
  serial_ripple_subtractor_if #(.n(8)) if8 ();

  serial_ripple_subtractor #(.n(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  serial_ripple_subtractor #(.n(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One n=4 operation. Operands are scrambled while busy to show they are ignored.
  task automatic op4(input int a, input int b, input string tag);
    int busy_cnt = 0;
    bit seen = 0;
    @(negedge clk);
    if4.start = 1'b1; if4.A = 4'(a); if4.B = 4'(b);
    @(negedge clk);
    if4.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (if4.done) begin seen = 1; break; end
      if (if4.busy) busy_cnt++;
      if4.A = 4'($urandom); if4.B = 4'($urandom);
      @(negedge clk);
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
    chk({tag, "_busy"}, 32'(busy_cnt), 32'd4);
    chk({tag, "_D"}, 32'(if4.D), 32'((a - b) & 15));
    chk({tag, "_Bout"}, 32'(if4.Bout), 32'(a < b));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(if4.done), 32'd0);
    chk({tag, "_hold"}, 32'(if4.D), 32'((a - b) & 15));
  endtask

  task automatic op8(input int a, input int b);
    int busy_cnt = 0;
    bit seen = 0;
    @(negedge clk);
    if8.start = 1'b1; if8.A = 8'(a); if8.B = 8'(b);
    @(negedge clk);
    if8.start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (if8.done) begin seen = 1; break; end
      if (if8.busy) busy_cnt++;
      if8.A = 8'($urandom); if8.B = 8'($urandom);
      @(negedge clk);
    end
    chk("op8_done", 32'(seen), 32'd1);
    chk("op8_busy", 32'(busy_cnt), 32'd8);
    chk("op8_D", 32'(if8.D), 32'((a - b) & 255));
    chk("op8_Bout", 32'(if8.Bout), 32'(a < b));
  endtask

  initial begin
    int ndone, last;
    if4.start = 0; if4.A = 0; if4.B = 0;
    if8.start = 0; if8.A = 0; if8.B = 0;
    #12;
    chk("rst_D4", 32'(if4.D), 0);
    chk("rst_Bout4", 32'(if4.Bout), 0);
    chk("rst_busy4", 32'(if4.busy), 0);
    chk("rst_done4", 32'(if4.done), 0);
    chk("rst_D8", 32'(if8.D), 0);
    @(negedge clk); rst_n = 1'b1;

    op4(9, 4, "t1");
    op4(4, 9, "t2a");
    op4(15, 15, "t2b");
    op4(0, 1, "t2c");

    // Reset after two RUN edges. Bout is still 1 from the previous op.
    @(negedge clk);
    if4.start = 1; if4.A = 4'd12; if4.B = 4'd5;
    @(negedge clk); if4.start = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_busy_pre", 32'(if4.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_D", 32'(if4.D), 0);
    chk("t5_Bout", 32'(if4.Bout), 0);
    chk("t5_busy", 32'(if4.busy), 0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if4.done) ndone++;
      if (i == 2) rst_n = 1'b1;
    end
    chk("t5_nodone", 32'(ndone), 0);
    op4(3, 3, "t5_new");

    // A re-pulse of start during RUN must not disturb the operation.
    @(negedge clk);
    if4.start = 1; if4.A = 4'd7; if4.B = 4'd2;
    @(negedge clk); if4.start = 0;
    @(negedge clk); if4.start = 1; if4.A = 4'd1; if4.B = 4'd8;
    @(negedge clk); if4.start = 0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (if4.done) begin
        ndone++;
        chk("t3_D", 32'(if4.D), 5);
        chk("t3_Bout", 32'(if4.Bout), 0);
      end
      @(negedge clk);
    end
    chk("t3_single", 32'(ndone), 1);

    // With start held high, done should pulse every n+1 cycles.
    if4.start = 1; if4.A = 4'd6; if4.B = 4'd3;
    ndone = 0; last = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (if4.done) begin
        chk("t4_D", 32'(if4.D), 3);
        if (last >= 0) chk("t4_gap", 32'(c - last), 5);
        last = c;
        ndone++;
      end
    end
    if4.start = 0;
    chk("t4_count", 32'(ndone), 4);
    @(negedge clk); @(negedge clk);

    op8(200, 57);
    for (int k = 0; k < 1000; k++) begin
      op8(int'($urandom_range(255)), int'($urandom_range(255)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
